// File: rtl/compositor_pkg.sv
// Shared types for the layer compositor: colour/depth types and the winner-select record.
package compositor_pkg;

  localparam int DEFAULT_COLOR_W = 12;
  localparam int DEFAULT_DEPTH_W = 9;
  localparam int MAX_LAYERS      = 8;
  localparam int INDEX_W         = 3;

  typedef logic [DEFAULT_COLOR_W-1:0] color_t;
  typedef logic [DEFAULT_DEPTH_W-1:0] depth_t;

  localparam color_t COLOR_TRANSPARENT = 12'hFFF;

  typedef struct packed {
    logic               valid;
    logic [INDEX_W-1:0] index;
  } layer_sel_t;

endpackage

// File: rtl/priority_select.sv
// Combinational argmax over the candidate sprite layers; ties resolve to the lowest index.
module priority_select
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int DEPTH_W    = 9
) (
  input  logic [NUM_LAYERS-1:0]         cand,
  input  logic [NUM_LAYERS*DEPTH_W-1:0] depth,
  output layer_sel_t                    sel
);

  localparam int LEAVES = MAX_LAYERS;

  logic [LEAVES-1:0]         cand_pad;
  logic [LEAVES*DEPTH_W-1:0] depth_pad;
  logic                      node_valid [1:2*LEAVES-1];
  logic [DEPTH_W-1:0]        node_depth [1:2*LEAVES-1];
  logic [INDEX_W-1:0]        node_index [1:2*LEAVES-1];
  logic                      take_left;

  // Heap-ordered tree: leaves at LEAVES..2*LEAVES-1, root at 1. The left child
  // always covers lower indices, so ">=" gives the lowest-index tie-break.
  always_comb begin
    cand_pad  = '0;
    depth_pad = '0;
    cand_pad[NUM_LAYERS-1:0]          = cand;
    depth_pad[NUM_LAYERS*DEPTH_W-1:0] = depth;
    take_left = 1'b0;
    for (int i = 0; i < LEAVES; i++) begin
      node_valid[LEAVES+i] = cand_pad[i];
      node_depth[LEAVES+i] = depth_pad[i*DEPTH_W +: DEPTH_W];
      node_index[LEAVES+i] = INDEX_W'(i);
    end
    for (int n = LEAVES-1; n >= 1; n--) begin
      take_left = node_valid[2*n] &&
                  (!node_valid[2*n+1] || (node_depth[2*n] >= node_depth[2*n+1]));
      node_valid[n] = node_valid[2*n] || node_valid[2*n+1];
      node_depth[n] = take_left ? node_depth[2*n] : node_depth[2*n+1];
      node_index[n] = take_left ? node_index[2*n] : node_index[2*n+1];
    end
    sel.valid = node_valid[1];
    sel.index = node_index[1];
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite/object/floor compositor with frame-start shadowed depth keys and enables.
// Optional build macro LAYER_COMPOSITOR_BLANK_EN forces pixel_out to 0 during blanking.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int               NUM_LAYERS  = 4,
  parameter int               COLOR_W     = 12,
  parameter int               DEPTH_W     = 9,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 12'hFFF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pixel_in,
  input  logic [NUM_LAYERS*DEPTH_W-1:0] layer_depth_in,
  input  logic [NUM_LAYERS-1:0]         layer_en_in,
  input  logic [COLOR_W-1:0]            object_pixel_in,
  input  logic [COLOR_W-1:0]            floor_pixel_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          blank_in,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          blank_out,
  output logic [COLOR_W-1:0]            pixel_out,
  output logic [15:0]                   frame_count
);

  logic                          vsync_prev;
  logic                          frame_start;
  logic [NUM_LAYERS-1:0]         shadow_en;
  logic [NUM_LAYERS*DEPTH_W-1:0] shadow_depth;
  logic [NUM_LAYERS-1:0]         eff_en;
  logic [NUM_LAYERS*DEPTH_W-1:0] eff_depth;
  logic [NUM_LAYERS-1:0]         cand;
  layer_sel_t                    sel;

  logic [NUM_LAYERS*COLOR_W-1:0] s1_layer;
  logic [COLOR_W-1:0]            s1_object;
  logic [COLOR_W-1:0]            s1_floor;
  logic                          s1_hsync;
  logic                          s1_vsync;
  logic                          s1_blank;
  layer_sel_t                    s1_sel;
  logic [COLOR_W-1:0]            next_pixel;

  assign frame_start = !vsync_in && vsync_prev;

  // On the frame-start edge the freshly captured keys already govern that pixel.
  assign eff_en    = frame_start ? layer_en_in    : shadow_en;
  assign eff_depth = frame_start ? layer_depth_in : shadow_depth;

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      cand[i] = eff_en[i] && (layer_pixel_in[i*COLOR_W +: COLOR_W] != TRANSPARENT);
    end
  end

  priority_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .DEPTH_W    (DEPTH_W)
  ) u_priority_select (
    .cand  (cand),
    .depth (eff_depth),
    .sel   (sel)
  );

  // vsync_prev resets low so a vsync already low at reset release is not a frame start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vsync_prev   <= 1'b0;
      shadow_en    <= '0;
      shadow_depth <= '0;
      frame_count  <= 16'd0;
    end else begin
      vsync_prev <= vsync_in;
      if (frame_start) begin
        shadow_en    <= layer_en_in;
        shadow_depth <= layer_depth_in;
        frame_count  <= frame_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_layer  <= '0;
      s1_object <= '0;
      s1_floor  <= '0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
      s1_blank  <= 1'b1;
      s1_sel    <= '0;
    end else begin
      s1_layer  <= layer_pixel_in;
      s1_object <= object_pixel_in;
      s1_floor  <= floor_pixel_in;
      s1_hsync  <= hsync_in;
      s1_vsync  <= vsync_in;
      s1_blank  <= blank_in;
      s1_sel    <= sel;
    end
  end

  always_comb begin
    next_pixel = (s1_object != TRANSPARENT) ? s1_object : s1_floor;
    if (s1_sel.valid) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (s1_sel.index == INDEX_W'(i)) begin
          next_pixel = s1_layer[i*COLOR_W +: COLOR_W];
        end
      end
    end
`ifdef LAYER_COMPOSITOR_BLANK_EN
    if (s1_blank) begin
      next_pixel = '0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
      pixel_out <= '0;
    end else begin
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
      blank_out <= s1_blank;
      pixel_out <= next_pixel;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_layer_compositor;

  localparam int NL = 4;
  localparam int CW = 12;
  localparam int DW = 9;
  localparam logic [CW-1:0] TR = 12'hFFF;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NL*CW-1:0]  layer_pixel_in;
  logic [NL*DW-1:0]  layer_depth_in;
  logic [NL-1:0]     layer_en_in;
  logic [CW-1:0]     object_pixel_in;
  logic [CW-1:0]     floor_pixel_in;
  logic              hsync_in, vsync_in, blank_in;
  logic              hsync_out, vsync_out, blank_out;
  logic [CW-1:0]     pixel_out;
  logic [15:0]       frame_count;

  always #5 clock = ~clock;

  layer_compositor #(
    .NUM_LAYERS  (NL),
    .COLOR_W     (CW),
    .DEPTH_W     (DW),
    .TRANSPARENT (TR)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .layer_pixel_in  (layer_pixel_in),
    .layer_depth_in  (layer_depth_in),
    .layer_en_in     (layer_en_in),
    .object_pixel_in (object_pixel_in),
    .floor_pixel_in  (floor_pixel_in),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .blank_in        (blank_in),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .blank_out       (blank_out),
    .pixel_out       (pixel_out),
    .frame_count     (frame_count)
  );

  // Stimulus state, applied to the DUT once per cycle
  logic [CW-1:0] lp [NL];
  logic [DW-1:0] ld [NL];
  logic [NL-1:0] len;
  logic [CW-1:0] obj, flr;
  logic          hs, vs, bl;
  bit            release_pending;

  typedef struct {
    logic          hs;
    logic          vs;
    logic          bl;
    logic [CW-1:0] pix;
  } out_t;

  out_t          exp_q [$];
  logic          m_prev_vs;
  logic [NL-1:0] m_en;
  logic [DW-1:0] m_depth [NL];
  logic [15:0]   m_fc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    out_t idle;
    idle.hs = 1'b1; idle.vs = 1'b1; idle.bl = 1'b1; idle.pix = '0;
    exp_q.delete();
    exp_q.push_back(idle);
    m_prev_vs = 1'b0;
    m_en      = '0;
    m_fc      = 16'd0;
    for (int i = 0; i < NL; i++) m_depth[i] = '0;
  endtask

  // Highest depth wins, first (lowest) index kept on ties; then object, then floor.
  function automatic logic [CW-1:0] composite();
    int best = -1;
    for (int i = 0; i < NL; i++) begin
      if (m_en[i] && lp[i] != TR) begin
        if (best < 0) best = i;
        else if (m_depth[i] > m_depth[best]) best = i;
      end
    end
    if (best >= 0) return lp[best];
    if (obj != TR) return obj;
    return flr;
  endfunction

  task automatic apply();
    for (int i = 0; i < NL; i++) begin
      layer_pixel_in[i*CW +: CW] = lp[i];
      layer_depth_in[i*DW +: DW] = ld[i];
    end
    layer_en_in     = len;
    object_pixel_in = obj;
    floor_pixel_in  = flr;
    hsync_in        = hs;
    vsync_in        = vs;
    blank_in        = bl;
  endtask

  task automatic cycle();
    out_t e, got;
    @(negedge clock);
    apply();
    if (release_pending) begin
      reset = 1'b1;
      release_pending = 1'b0;
    end
    if (!vs && m_prev_vs) begin
      m_en = len;
      for (int i = 0; i < NL; i++) m_depth[i] = ld[i];
      m_fc = m_fc + 16'd1;
    end
    m_prev_vs = vs;
    e.hs  = hs;
    e.vs  = vs;
    e.bl  = bl;
    e.pix = composite();
`ifdef LAYER_COMPOSITOR_BLANK_EN
    if (bl) e.pix = '0;
`endif
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    got = exp_q.pop_front();
    chk("hsync_out",   32'(hsync_out),   32'(got.hs));
    chk("vsync_out",   32'(vsync_out),   32'(got.vs));
    chk("blank_out",   32'(blank_out),   32'(got.bl));
    chk("pixel_out",   32'(pixel_out),   32'(got.pix));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_hsync", 32'(hsync_out),   32'h1);
    chk("rst_vsync", 32'(vsync_out),   32'h1);
    chk("rst_blank", 32'(blank_out),   32'h1);
    chk("rst_pixel", 32'(pixel_out),   32'h0);
    chk("rst_fc",    32'(frame_count), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold_fc", 32'(frame_count), 32'h0);
    model_reset();
    release_pending = 1'b1;
  endtask

  int vs_left;

  initial begin
    lp[0] = 12'h111; lp[1] = 12'h222; lp[2] = 12'h333; lp[3] = 12'h444;
    ld[0] = 9'd50;   ld[1] = 9'd120;  ld[2] = 9'd120;  ld[3] = 9'd10;
    len = 4'hF; obj = 12'h0F0; flr = 12'h0A0;
    hs = 1'b1; vs = 1'b0; bl = 1'b0;
    apply();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_pixel", 32'(pixel_out), 32'h0);
    chk("reset_blank", 32'(blank_out), 32'h1);
    release_pending = 1'b1;

    // vsync held low through release: no frame start, sprites still hidden
    repeat (3) cycle();
    chk("pre_frame_pixel", 32'(pixel_out),   32'h0F0);
    chk("pre_frame_fc",    32'(frame_count), 32'h0);
    vs = 1'b1;
    repeat (3) cycle();
    chk("vs_high_fc", 32'(frame_count), 32'h0);
    vs = 1'b0;
    cycle();
    chk("first_frame_fc", 32'(frame_count), 32'h1);
    cycle();
    chk("depth_tie_pixel", 32'(pixel_out), 32'h222);

    for (int i = 0; i < NL; i++) lp[i] = TR;
    obj = 12'hF00;
    repeat (2) cycle();
    chk("object_pixel", 32'(pixel_out), 32'hF00);
    obj = TR;
    repeat (2) cycle();
    chk("floor_pixel", 32'(pixel_out), 32'h0A0);

    lp[0] = 12'h111; lp[1] = 12'h222; lp[2] = 12'h333; lp[3] = 12'h444;
    obj = 12'h0F0;
    ld[3] = 9'd300;
    repeat (4) cycle();
    chk("midframe_hold", 32'(pixel_out), 32'h222);
    vs = 1'b1;
    repeat (2) cycle();
    vs = 1'b0;
    repeat (2) cycle();
    chk("new_frame_l3",  32'(pixel_out),   32'h444);
    chk("second_fc",     32'(frame_count), 32'h2);

    // Sync pulse pattern with blanking
    for (int k = 0; k < 16; k++) begin
      hs = (k % 5) != 2;
      bl = (k % 7) < 2;
      vs = (k < 10);
      cycle();
    end

    vs_left = 10;
    for (int c = 0; c < 3000; c++) begin
      if (vs_left == 0) begin
        vs = ~vs;
        vs_left = vs ? int'($urandom_range(40, 5)) : int'($urandom_range(6, 1));
      end
      vs_left--;
      hs = ($urandom % 8) != 0;
      bl = ($urandom % 4) == 0;
      for (int i = 0; i < NL; i++) begin
        lp[i] = (($urandom % 3) == 0) ? TR : CW'($urandom);
        ld[i] = ($urandom % 2) ? DW'($urandom % 4) : DW'($urandom);
      end
      len = NL'($urandom);
      obj = ($urandom % 2) ? TR : CW'($urandom);
      flr = CW'($urandom);
      cycle();
      if (c == 1500) mid_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
